// File: rtl/br_pred_table_if.sv
// Pipeline-facing bundle of the branch predictor: ID-stage lookup and
// resolution-stage training share one interface.
interface br_pred_table_if #(
  parameter int ls = 8,
  parameter int gs = 6
);
  logic [15:0]   pc;
  logic          lookup_taken;
  logic [1:0]    lookup_pred;
  logic [ls-1:0] lookup_local_index;
  logic [gs-1:0] lookup_global_index;

  logic          update_valid;
  logic          update_taken;
  logic          update_predicted_taken;
  logic [1:0]    update_pred;
  logic [ls-1:0] update_local_index;
  logic [gs-1:0] update_global_index;

  logic          mispredict;
  logic [15:0]   branch_count;
  logic [15:0]   mispredict_count;

  // Pipeline side: drives the PC and resolved branches, consumes predictions.
  modport master (
    output pc, update_valid, update_taken, update_predicted_taken,
           update_pred, update_local_index, update_global_index,
    input  lookup_taken, lookup_pred, lookup_local_index, lookup_global_index,
           mispredict, branch_count, mispredict_count
  );

  // Predictor side.
  modport slave (
    input  pc, update_valid, update_taken, update_predicted_taken,
           update_pred, update_local_index, update_global_index,
    output lookup_taken, lookup_pred, lookup_local_index, lookup_global_index,
           mispredict, branch_count, mispredict_count
  );
endinterface

// File: rtl/br_pred_table.sv
// Tournament branch predictor: local PHT, gshare global PHT and a chooser,
// with combinational lookup and single-cycle non-speculative training.
module br_pred_table #(
  parameter int ls = 8,
  parameter int gs = 6
) (
  input  logic            clk,
  input  logic            reset,
  br_pred_table_if.slave  bp
);

  localparam int LN = 1 << ls;
  localparam int GN = 1 << gs;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_INIT = 2'b01;

  function automatic ctr_t sat_step(input ctr_t c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'd1;
    else    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  ctr_t          r_lpht    [LN];
  ctr_t          r_gpht    [GN];
  ctr_t          r_chooser [GN];
  logic [gs-1:0] r_ghr;
  logic          r_mispredict;
  logic [15:0]   r_branch_count;
  logic [15:0]   r_mispredict_count;

  logic [ls-1:0] w_li;
  logic [gs-1:0] w_gi;
  logic [1:0]    w_pred;
  logic          w_local_ok;
  logic          w_global_ok;
  logic          w_unused_pc;

  // ---------------------------------------------------------------- lookup
  assign w_li   = bp.pc[ls:1];
  assign w_gi   = bp.pc[gs:1] ^ r_ghr;
  assign w_pred = {r_lpht[w_li][1], r_gpht[w_gi][1]};

  assign bp.lookup_local_index  = w_li;
  assign bp.lookup_global_index = w_gi;
  assign bp.lookup_pred         = w_pred;
  assign bp.lookup_taken        = r_chooser[w_gi][1] ? w_pred[0] : w_pred[1];

  // Bits of the PC that do not participate in indexing.
  assign w_unused_pc = ^{bp.pc[15:ls+1], bp.pc[0]};

  // ---------------------------------------------------------------- update
  assign w_local_ok  = (bp.update_pred[1] == bp.update_taken);
  assign w_global_ok = (bp.update_pred[0] == bp.update_taken);

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the tables are reset entry by entry because every counter must
      // start weakly not-taken / weakly local; this keeps them in flops rather
      // than a RAM macro, which cannot be cleared in one cycle.
      for (int i = 0; i < LN; i++) r_lpht[i] <= CTR_INIT;
      for (int i = 0; i < GN; i++) begin
        r_gpht[i]    <= CTR_INIT;
        r_chooser[i] <= CTR_INIT;
      end
      r_ghr              <= '0;
      r_mispredict       <= 1'b0;
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else if (bp.update_valid) begin
      // NOTE: non-blocking assignments make every read below see pre-edge
      // state, so back-to-back updates to one entry chain cleanly.
      r_lpht[bp.update_local_index]  <= sat_step(r_lpht[bp.update_local_index], bp.update_taken);
      r_gpht[bp.update_global_index] <= sat_step(r_gpht[bp.update_global_index], bp.update_taken);

      // Chooser only moves when exactly one component was right.
      if (w_local_ok != w_global_ok)
        r_chooser[bp.update_global_index] <=
          sat_step(r_chooser[bp.update_global_index], w_global_ok);

      r_ghr <= {r_ghr[gs-2:0], bp.update_taken};

      if (r_branch_count != 16'hFFFF) r_branch_count <= r_branch_count + 16'd1;

      if (bp.update_taken != bp.update_predicted_taken) begin
        r_mispredict <= 1'b1;
        if (r_mispredict_count != 16'hFFFF)
          r_mispredict_count <= r_mispredict_count + 16'd1;
      end else begin
        r_mispredict <= 1'b0;
      end
    end else begin
      r_mispredict <= 1'b0;
    end
  end

  assign bp.mispredict       = r_mispredict;
  assign bp.branch_count     = r_branch_count;
  assign bp.mispredict_count = r_mispredict_count;

endmodule
